// File: rtl/fft_io_controller_pkg.sv
// fft_consts: shared constants, types and helpers for the FFT I/O controller
//   N_LOG2/DATA_W  default transform size and component width
//   cplx_t         packed {re,im} sample
//   io_state_t     controller FSM states
//   bitrev()       reverses the w LSBs of k
package fft_consts;
  localparam int N_LOG2 = 3;
  localparam int DATA_W = 16;
  typedef struct packed {
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
  } cplx_t;
  typedef enum logic [1:0] {S_LOAD, S_START, S_COMPUTE, S_UNLOAD} io_state_t;
  function automatic logic [31:0] bitrev(input logic [31:0] k, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = k[w-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_out_skid.sv
// fft_out_skid: 2-entry FIFO feeding the output stream
//   push/push_data       write side, one entry per cycle
//   pop_valid/pop_ready  valid/ready read side, pop_data is the oldest entry
//   count                current occupancy (0..2)
module fft_out_skid #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         pop_valid,
  input  logic         pop_ready,
  output logic [W-1:0] pop_data,
  output logic [1:0]   count
);
  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic wr_q, wr_d, rd_q, rd_d, pop;
  logic [1:0] cnt_q, cnt_d;
  always_comb begin
    pop_valid = cnt_q != 2'd0;
    pop_data = mem_q[rd_q];
    count = cnt_q;
    pop = pop_valid && pop_ready;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = push_data;
    wr_d = wr_q ^ push;
    rd_d = rd_q ^ pop;
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem_q <= '{default: '0};
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/fft_io_controller.sv
// fft_io_controller: frames one FFT (bit-reversed load, AGU compute, natural-order unload)
//   s_*        input sample stream, written to bank 0 via ld_*
//   agu_*      level start/done handshake with the address generation unit
//   ul_*       result-bank reads, data returns one cycle after ul_re
//   m_*        output sample stream through a 2-entry skid, m_last on sample N-1
//   busy       high outside LOAD
module fft_io_controller #(
  parameter int N_LOG2 = fft_consts::N_LOG2,
  parameter int DATA_W = fft_consts::DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [2*DATA_W-1:0] s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [2*DATA_W-1:0] m_data,
  output logic                m_last,
  output logic                agu_start,
  input  logic                agu_done,
  input  logic                agu_bank_sel,
  output logic                ld_we,
  output logic [N_LOG2-1:0]   ld_addr,
  output logic [2*DATA_W-1:0] ld_wdata,
  output logic                ul_re,
  output logic                ul_bank,
  output logic [N_LOG2-1:0]   ul_addr,
  input  logic [2*DATA_W-1:0] ul_rdata,
  output logic                busy
);
  import fft_consts::*;
  localparam int CW = N_LOG2 + 1;
  localparam logic [CW-1:0] N = CW'(1 << N_LOG2);
  io_state_t state_q, state_d;
  logic [CW-1:0] load_cnt_q, load_cnt_d, rd_cnt_q, rd_cnt_d, out_cnt_q, out_cnt_d;
  logic res_bank_q, res_bank_d, inflight_q, inflight_d;
  logic ld_hs, pop;
  logic [1:0] skid_cnt;
  logic [2:0] occ;
  fft_out_skid #(.W(2*DATA_W)) u_skid (
    .clk(clk),
    .rst(rst),
    .push(inflight_q),
    .push_data(ul_rdata),
    .pop_valid(m_valid),
    .pop_ready(m_ready),
    .pop_data(m_data),
    .count(skid_cnt)
  );
  always_comb begin
    state_d = state_q;
    load_cnt_d = load_cnt_q;
    rd_cnt_d = rd_cnt_q;
    out_cnt_d = out_cnt_q;
    res_bank_d = res_bank_q;
    s_ready = state_q == S_LOAD;
    busy = !s_ready;
    agu_start = state_q == S_START || state_q == S_COMPUTE;
    ld_hs = s_valid && s_ready;
    ld_we = ld_hs;
    ld_addr = ld_hs ? N_LOG2'(bitrev(32'(load_cnt_q), N_LOG2)) : '0;
    ld_wdata = ld_hs ? s_data : '0;
    pop = m_valid && m_ready;
    m_last = m_valid && out_cnt_q == N - 1'b1;
    // Occupancy after this cycle's pop: counting the pop keeps 1 beat/cycle.
    occ = 3'(skid_cnt) + 3'(inflight_q) - 3'(pop);
    ul_re = state_q == S_UNLOAD && rd_cnt_q < N && occ < 3'd2;
    ul_addr = ul_re ? rd_cnt_q[N_LOG2-1:0] : '0;
    ul_bank = state_q == S_UNLOAD && res_bank_q;
    inflight_d = ul_re;
    unique case (state_q)
      S_LOAD:
        if (ld_hs) begin
          load_cnt_d = load_cnt_q == N - 1'b1 ? '0 : load_cnt_q + 1'b1;
          state_d = load_cnt_q == N - 1'b1 ? S_START : S_LOAD;
        end
      S_START: state_d = S_COMPUTE;
      S_COMPUTE:
        if (agu_done) begin
          res_bank_d = ~agu_bank_sel;
          state_d = S_UNLOAD;
        end
      S_UNLOAD: begin
        rd_cnt_d = ul_re ? rd_cnt_q + 1'b1 : rd_cnt_q;
        out_cnt_d = pop ? out_cnt_q + 1'b1 : out_cnt_q;
        if (pop && m_last) begin
          state_d = S_LOAD;
          load_cnt_d = '0;
          rd_cnt_d = '0;
          out_cnt_d = '0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_LOAD;
      load_cnt_q <= '0;
      rd_cnt_q <= '0;
      out_cnt_q <= '0;
      res_bank_q <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      state_q <= state_d;
      load_cnt_q <= load_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      out_cnt_q <= out_cnt_d;
      res_bank_q <= res_bank_d;
      inflight_q <= inflight_d;
    end
endmodule

// File: tb/tb_fft_io_controller.sv
// tb_fft_io_controller: scoreboard bench with AGU and ping-pong RAM models
module tb_fft_io_controller;
  localparam int NL = 3;
  localparam int DW = 16;
  localparam int N = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic s_valid = 1'b0;
  logic s_ready;
  logic [2*DW-1:0] s_data = '0;
  logic m_valid, m_last;
  logic m_ready = 1'b1;
  logic [2*DW-1:0] m_data;
  logic agu_start;
  logic agu_done = 1'b0;
  logic agu_bank_sel = 1'b1;
  logic ld_we, ul_re, ul_bank, busy;
  logic [NL-1:0] ld_addr, ul_addr;
  logic [2*DW-1:0] ld_wdata;
  logic [2*DW-1:0] ul_rdata = '0;
  fft_io_controller dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .agu_start(agu_start), .agu_done(agu_done), .agu_bank_sel(agu_bank_sel),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ul_re(ul_re), .ul_bank(ul_bank), .ul_addr(ul_addr), .ul_rdata(ul_rdata),
    .busy(busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  logic [NL+2*DW-1:0] ldq[$];
  logic [2*DW:0] outq[$];
  logic [NL-1:0] brev_tab [N] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
  logic [2*DW-1:0] ram [2][N];
  int res_off = 0;
  bit rnd_ready = 1'b0;
  // AGU model: done 20 cycles after start rises, writes results into bank ~bank_sel.
  int agu_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (rst || !agu_start) begin
      agu_cnt = 0;
      agu_done = 1'b0;
    end else begin
      agu_cnt++;
      if (agu_cnt > 20 && !agu_done) begin
        agu_done = 1'b1;
        for (int a = 0; a < N; a++) ram[!agu_bank_sel][a] = 32'(a * 3 + res_off);
      end
    end
  end
  // RAM model: writes and read requests sampled mid-cycle, read data driven next cycle.
  bit rd_pend = 1'b0;
  logic rd_bank;
  logic [NL-1:0] rd_addr;
  always @(negedge clk) begin
    if (ld_we) ram[0][ld_addr] = ld_wdata;
    rd_pend = ul_re;
    rd_bank = ul_bank;
    rd_addr = ul_addr;
  end
  always @(posedge clk) begin
    #1;
    ul_rdata = rd_pend ? ram[rd_bank][rd_addr] : '0;
    m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  int ld_writes = 0, beats = 0, frames = 0;
  int first_cyc = 0, last_cyc = 0, done_cyc = 0, first_valid_cyc = 0;
  bit seen_valid = 1'b0, prev_stall = 1'b0, prev_start = 1'b0, prev_done = 1'b0;
  logic [2*DW-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_start = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (ld_we) begin
        chk("ld_write_expected", ldq.size() != 0, 1);
        if (ldq.size() != 0) begin
          logic [NL+2*DW-1:0] e;
          e = ldq.pop_front();
          chk("ld_addr", ld_addr, e[NL+2*DW-1:2*DW]);
          chk("ld_wdata", ld_wdata, e[2*DW-1:0]);
        end
        ld_writes++;
      end
      if (prev_stall) chk("m_data_hold", m_data, prev_data);
      prev_stall = m_valid && !m_ready;
      prev_data = m_data;
      if (m_valid && !seen_valid) begin
        seen_valid = 1'b1;
        first_valid_cyc = cyc;
      end
      if (m_valid && m_ready) begin
        chk("beat_expected", outq.size() != 0, 1);
        if (outq.size() != 0) begin
          logic [2*DW:0] e;
          e = outq.pop_front();
          chk("m_data", m_data, e[2*DW:1]);
          chk("m_last", m_last, e[0]);
        end
        if (beats == 0) first_cyc = cyc;
        beats++;
        if (m_last) begin
          frames++;
          last_cyc = cyc;
        end
      end
      if (m_valid) chk("s_ready_unload", s_ready, 0);
      if (ul_re) chk("ul_bank", ul_bank, 0);
      if (prev_start && !prev_done) chk("agu_start_hold", agu_start, 1);
      if (prev_done) chk("agu_start_drop", agu_start, 0);
      if (agu_start) chk("s_ready_compute", s_ready, 0);
      if (agu_done) done_cyc = cyc;
      prev_start = agu_start;
      prev_done = agu_done;
    end
  end
  task automatic load_frame(input bit gaps);
    for (int k = 0; k < N; k++) begin
      logic [2*DW-1:0] d;
      if (gaps && k > 0) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      d = {16'(k), 16'(16'h0100 + k)};
      ldq.push_back({brev_tab[k], d});
      s_valid = 1'b1;
      s_data = d;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    @(negedge clk);
    chk("start_after_load", agu_start, 1);
    chk("busy_in_start", busy, 1);
  endtask
  task automatic push_expected(input int off);
    for (int a = 0; a < N; a++) outq.push_back({32'(a * 3 + off), a == N - 1});
  endtask
  task automatic run_frame(input bit gaps, input bit rnd, input int off);
    int f0;
    res_off = off;
    rnd_ready = rnd;
    ld_writes = 0;
    beats = 0;
    seen_valid = 1'b0;
    push_expected(off);
    load_frame(gaps);
    @(posedge clk);
    #1;
    s_valid = 1'b1;
    s_data = 32'hbad0bad0;
    repeat (5) @(posedge clk);
    #1;
    s_valid = 1'b0;
    f0 = frames;
    for (int i = 0; i < 400 && frames == f0; i++) @(posedge clk);
    if (frames == f0) chk("frame_timeout", frames, f0 + 1);
    @(negedge clk);
    chk("s_ready_after_frame", s_ready, 1);
    chk("busy_after_frame", busy, 0);
    chk("m_valid_after_frame", m_valid, 0);
    chk("ld_write_count", ld_writes, N);
    chk("beat_count", beats, N);
    if (!rnd) begin
      chk("beat_span", last_cyc - first_cyc, N - 1);
      chk("first_valid_latency", first_valid_cyc - done_cyc, 3);
    end
    rnd_ready = 1'b0;
  endtask
  initial begin
    for (int a = 0; a < N; a++) ram[1][a] = 32'hdead0000 + 32'(a);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_agu_start", agu_start, 0);
    chk("rst_ld_we", ld_we, 0);
    chk("rst_ul_re", ul_re, 0);
    chk("rst_m_last", m_last, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame(1'b0, 1'b0, 0);
    run_frame(1'b1, 1'b1, 0);
    res_off = 50;
    rnd_ready = 1'b0;
    beats = 0;
    push_expected(50);
    load_frame(1'b0);
    for (int i = 0; i < 400 && beats < 3; i++) @(posedge clk);
    chk("beats_before_reset", beats, 3);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_s_ready", s_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_agu_start", agu_start, 0);
    outq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame(1'b0, 1'b0, 100);
    chk("outq_empty", outq.size(), 0);
    chk("ldq_empty", ldq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL global_timeout: cycle=%0d limit reached", cyc);
    $fatal(1);
  end
endmodule
